// File: rtl/axis_hdr_pkg.sv
// axis_hdr_pkg: shared state encoding and width defaults for the header arbiter.
package axis_hdr_pkg;
    localparam int DATA_WD_DEF  = 32;
    localparam int BYTE_WD_DEF  = DATA_WD_DEF / 8;
    localparam int STATE_WD     = 2;
    typedef enum logic [STATE_WD-1:0] {IDLE, OFFER, PKT} state_e;
endpackage

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: combinational request picker, round-robin from ptr by default;
// AXIS_HDR_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority.
module axis_rr_arbiter #(
    parameter int N      = 4,
    parameter int IDX_WD = $clog2(N)
) (
    input  logic [N-1:0]      req,
    input  logic [IDX_WD-1:0] ptr,
    output logic [N-1:0]      gnt,
    output logic [IDX_WD-1:0] idx
);
    logic [IDX_WD-1:0] base;
    logic [IDX_WD-1:0] c;
    logic              found;
`ifdef AXIS_HDR_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign base       = '0;
    assign unused_ptr = ^ptr;
`else
    assign base = ptr;
`endif
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int i = 0; i < N; i++) begin
            c = IDX_WD'((int'(base) + i) % N);
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end
endmodule

// File: rtl/axis_header_arbiter.sv
// axis_header_arbiter: grants one header per packet from N_SRC sources to the insert port,
// holding the next grant until the output packet's last beat (AXIS_HDR_ARB_FIXED_PRIO_EN: fixed priority).
module axis_header_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = DATA_WD_DEF,
    parameter int DATA_BYTE_WD = BYTE_WD_DEF,
    parameter int N_SRC        = 4,
    parameter int IDX_WD       = $clog2(N_SRC)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_SRC-1:0]                src_valid,
    input  logic [N_SRC*DATA_WD-1:0]        src_data,
    input  logic [N_SRC*DATA_BYTE_WD-1:0]   src_keep,
    output logic [N_SRC-1:0]                src_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    input  logic                            ready_insert,
    input  logic                            mon_valid,
    input  logic                            mon_ready,
    input  logic                            mon_last,
    output logic [IDX_WD-1:0]               grant_idx,
    output logic                            busy
);
    state_e                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [IDX_WD-1:0]       grant_q, grant_d;
    logic [IDX_WD-1:0]       rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]        gnt;
    logic [IDX_WD-1:0]       win;
    logic                    pkt_done;
    logic [N_SRC-1:0]        pop;

    axis_rr_arbiter #(.N(N_SRC), .IDX_WD(IDX_WD)) u_arb (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (win)
    );

    assign pkt_done = mon_valid & mon_ready & mon_last;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        keep_d   = keep_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        pop      = '0;
        case (state_q)
            IDLE: if (|src_valid) begin
                pop     = gnt;
                data_d  = src_data[win*DATA_WD +: DATA_WD];
                keep_d  = src_keep[win*DATA_BYTE_WD +: DATA_BYTE_WD];
                grant_d = win;
`ifdef AXIS_HDR_ARB_FIXED_PRIO_EN
                rr_ptr_d = '0;
`else
                rr_ptr_d = (win == IDX_WD'(N_SRC - 1)) ? '0 : win + IDX_WD'(1);
`endif
                valid_d = 1'b1;
                state_d = OFFER;
            end
            // A packet may already finish in the same cycle the header is taken.
            OFFER: if (ready_insert) begin
                valid_d = 1'b0;
                state_d = pkt_done ? IDLE : PKT;
            end
            PKT: if (pkt_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign src_ready    = rst_n ? pop : '0;
    assign valid_insert = valid_q;
    assign data_insert  = data_q;
    assign keep_insert  = keep_q;
    assign grant_idx    = grant_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_axis_header_arbiter.sv
// tb_axis_header_arbiter: directed scoreboard bench for axis_header_arbiter.
module tb_axis_header_arbiter;
`ifdef AXIS_HDR_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src_valid;
    logic [127:0] src_data;
    logic [15:0] src_keep;
    logic [3:0]  src_ready;
    logic        valid_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic        ready_insert, mon_valid, mon_ready, mon_last;
    logic [1:0]  grant_idx;
    logic        busy;
    int total = 0;
    int bad   = 0;

    typedef struct {int idx; logic [31:0] d; logic [3:0] k;} hdr_t;
    hdr_t sb[$];
    logic [31:0] words [4] = '{32'hA1B2C3D4, 32'h11223344, 32'hDEADBEEF, 32'h5A5AA5A5};
    logic [3:0]  keeps [4] = '{4'hF, 4'h0, 4'h3, 4'h5};

    always #5 clk = ~clk;

    assign src_data = {words[3], words[2], words[1], words[0]};
    assign src_keep = {keeps[3], keeps[2], keeps[1], keeps[0]};

    axis_header_arbiter dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .src_keep(src_keep), .src_ready(src_ready), .valid_insert(valid_insert),
        .data_insert(data_insert), .keep_insert(keep_insert), .ready_insert(ready_insert),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
        .grant_idx(grant_idx), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int w);
        hdr_t h;
        h.idx = w;
        h.d   = words[w];
        h.k   = keeps[w];
        sb.push_back(h);
    endtask

    task automatic sb_cmp(input string tag);
        hdr_t h;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            total--;
            h = sb.pop_front();
            chk({tag, "_valid"}, 32'(valid_insert), 32'd1);
            chk({tag, "_idx"}, 32'(grant_idx), 32'(h.idx));
            chk({tag, "_data"}, data_insert, h.d);
            chk({tag, "_keep"}, 32'(keep_insert), 32'(h.k));
        end
    endtask

    task automatic serve(input string tag, input int w);
        #1;
        chk({tag, "_pop"}, 32'(src_ready), 32'(1 << w));
        push(w);
        step;
        sb_cmp(tag);
        chk({tag, "_offer_nopop"}, 32'(src_ready), 32'd0);
        ready_insert = 1'b1;
        step;
        ready_insert = 1'b0;
        chk({tag, "_pkt_busy"}, 32'(busy), 32'd1);
        chk({tag, "_pkt_valid"}, 32'(valid_insert), 32'd0);
        {mon_valid, mon_ready, mon_last} = 3'b111;
        step;
        {mon_valid, mon_ready, mon_last} = 3'b000;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        src_valid = 4'b1111;
        ready_insert = 1'b0;
        {mon_valid, mon_ready, mon_last} = 3'b000;
        #1;
        chk("rst_src_ready", 32'(src_ready), 32'd0);
        step;
        step;
        chk("rst_src_ready2", 32'(src_ready), 32'd0);
        chk("rst_valid", 32'(valid_insert), 32'd0);
        chk("rst_data", data_insert, 32'd0);
        chk("rst_keep", 32'(keep_insert), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        // pop from 0101 with pointer at 0
        rst_n = 1'b1;
        src_valid = 4'b0101;
        #1;
        chk("t1_pop", 32'(src_ready), 32'b0001);
        push(0);
        step;
        src_valid = 4'b0100;
        sb_cmp("t1");
        // OFFER held while insert port stalls
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_src_ready", 32'(src_ready), 32'd0);
            chk("t2_valid", 32'(valid_insert), 32'd1);
            chk("t2_data", data_insert, words[0]);
            chk("t2_keep", 32'(keep_insert), 32'(keeps[0]));
            step;
        end
        ready_insert = 1'b1;
        step;
        ready_insert = 1'b0;
        chk("t2_pkt_valid", 32'(valid_insert), 32'd0);
        chk("t2_pkt_busy", 32'(busy), 32'd1);
        chk("t2_pkt_nopop", 32'(src_ready), 32'd0);
        // last beat without ready does not finish the packet
        {mon_valid, mon_ready, mon_last} = 3'b101;
        step;
        chk("t4_stall_busy", 32'(busy), 32'd1);
        chk("t4_stall_nopop", 32'(src_ready), 32'd0);
        mon_ready = 1'b1;
        step;
        {mon_valid, mon_ready, mon_last} = 3'b000;
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_pop", 32'(src_ready), 32'b0100);
        push(2);
        step;
        src_valid = 4'b0000;
        sb_cmp("t4");
        // header accept and packet end together
        ready_insert = 1'b1;
        {mon_valid, mon_ready, mon_last} = 3'b111;
        step;
        ready_insert = 1'b0;
        {mon_valid, mon_ready, mon_last} = 3'b000;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_valid", 32'(valid_insert), 32'd0);
        chk("t5_keep", 32'(keep_insert), 32'b0011);
        chk("t5_nopop", 32'(src_ready), 32'd0);
        // reset during PKT
        src_valid = 4'b1111;
        #1;
        chk("t6_pop", 32'(src_ready), 32'(1 << (FP ? 0 : 3)));
        push(FP ? 0 : 3);
        step;
        sb_cmp("t6");
        ready_insert = 1'b1;
        step;
        ready_insert = 1'b0;
        chk("t6_pkt", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step;
        chk("t6_valid", 32'(valid_insert), 32'd0);
        chk("t6_data", data_insert, 32'd0);
        chk("t6_keep", 32'(keep_insert), 32'd0);
        chk("t6_grant", 32'(grant_idx), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_src_ready", 32'(src_ready), 32'd0);
        rst_n = 1'b1;
        // all sources valid: round-robin sweep from 0
        for (int k = 0; k < 4; k++)
            serve($sformatf("t3_%0d", k), FP ? 0 : k);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
